seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the per-thread ALU; one instance per thread in each core.
- Executes ADD, SUB and MUL in one cycle.
- Executes DIV with an iterative restoring divider, one quotient bit per cycle.
- Produces NZP compare flags for the branch unit.
- Uses a start/busy/done handshake so the core scheduler stalls on DIV instead of assuming single-cycle completion.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/seq_divider.sv | 66 ++++++
 rtl/seq_alu.sv | 127 ++++++++++++
 tb/tb_seq_alu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types and the branch-compare flag helper.
// Operands reach nzp_flags already extended to NZP_W according to the signedness in use.
package alu_pkg;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      MUL = 2'b10,
      DIV = 2'b11
   } alu_op_t;

   typedef enum logic {
      IDLE    = 1'b0,
      DIV_RUN = 1'b1
   } alu_state_t;

   localparam int NZP_W = 64;

   // Returns {gt, eq, lt}; exactly one bit is set.
   function automatic logic [2:0] nzp_flags(input logic [NZP_W-1:0] a,
                                            input logic [NZP_W-1:0] b,
                                            input logic             signed_mode);
      logic gt, eq, lt;
      eq = (a == b);
      if (signed_mode)
         lt = ($signed(a) < $signed(b));
      else
         lt = (a < b);
      gt = ~eq & ~lt;
      return {gt, eq, lt};
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the load edge performs the first step.
// Result on quotient (combinational) in the cycle last=1, DATA_WIDTH-1 cycles after load; no backpressure.
module seq_divider #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  busy,
   output logic                  last,
   output logic [DATA_WIDTH-1:0] quotient
);

   localparam int CW = $clog2(DATA_WIDTH);

   logic                  active_q;
   logic [CW-1:0]         cnt_q;
   logic [DATA_WIDTH-1:0] rem_q, dq_q, dsr_q;
   logic [DATA_WIDTH-1:0] rem_in, dq_in, dsr_in, rem_nx, dq_nx;
   logic [DATA_WIDTH:0]   shifted, diff;

   // dq holds the unconsumed dividend bits on top and the growing quotient below.
   always_comb begin
      rem_in  = load ? '0       : rem_q;
      dq_in   = load ? dividend : dq_q;
      dsr_in  = load ? divisor  : dsr_q;
      shifted = {rem_in, dq_in[DATA_WIDTH-1]};
      diff    = shifted - {1'b0, dsr_in};
      if (diff[DATA_WIDTH]) begin
         rem_nx = shifted[DATA_WIDTH-1:0];
         dq_nx  = {dq_in[DATA_WIDTH-2:0], 1'b0};
      end else begin
         rem_nx = diff[DATA_WIDTH-1:0];
         dq_nx  = {dq_in[DATA_WIDTH-2:0], 1'b1};
      end
   end

   assign busy     = active_q;
   assign last     = active_q & (cnt_q == CW'(DATA_WIDTH - 1));
   assign quotient = dq_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         rem_q    <= '0;
         dq_q     <= '0;
         dsr_q    <= '0;
      end else if (load) begin
         active_q <= 1'b1;
         cnt_q    <= CW'(1);
         rem_q    <= rem_nx;
         dq_q     <= dq_nx;
         dsr_q    <= divisor;
      end else if (active_q) begin
         rem_q <= rem_nx;
         dq_q  <= dq_nx;
         cnt_q <= cnt_q + CW'(1);
         if (last)
            active_q <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Per-thread ALU: ADD/SUB/MUL/compare done 1 cycle after start, DIV done DATA_WIDTH cycles after start.
// Starts arriving while busy or with enable=0 are dropped; busy is high from the accepting cycle of a DIV.
module seq_alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SIGNED_CMP = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  start,
   input  logic [1:0]            decoded_alu_arithmetic_mux,
   input  logic                  decoded_alu_output_mux,
   input  logic [DATA_WIDTH-1:0] rs,
   input  logic [DATA_WIDTH-1:0] rt,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero,
   output logic [DATA_WIDTH-1:0] alu_out
);

   alu_state_t            state_q, state_d;
   alu_op_t               op;
   logic [DATA_WIDTH-1:0] alu_out_q, alu_out_d;
   logic                  done_q, done_d;
   logic                  dbz_q, dbz_d;
   logic                  accept, div_go;
   logic                  div_busy, div_last;
   logic [DATA_WIDTH-1:0] div_quot;
   logic [NZP_W-1:0]      rs_x, rt_x;
   logic [2:0]            flags;

   assign op     = alu_op_t'(decoded_alu_arithmetic_mux);
   assign accept = start & enable & (state_q == IDLE);
   assign div_go = accept & ~decoded_alu_output_mux & (op == DIV) & (rt != '0);

   always_comb begin
      if (SIGNED_CMP != 0) begin
         rs_x = NZP_W'($signed(rs));
         rt_x = NZP_W'($signed(rt));
      end else begin
         rs_x = NZP_W'(rs);
         rt_x = NZP_W'(rt);
      end
   end

   assign flags = nzp_flags(rs_x, rt_x, SIGNED_CMP != 0);

   seq_divider #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (div_go),
      .dividend (rs),
      .divisor  (rt),
      .busy     (div_busy),
      .last     (div_last),
      .quotient (div_quot)
   );

   always_comb begin
      state_d   = state_q;
      alu_out_d = alu_out_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               done_d = 1'b1;
               dbz_d  = 1'b0;
               if (decoded_alu_output_mux) begin
                  alu_out_d      = '0;
                  alu_out_d[2:0] = flags;
               end else begin
                  case (op)
                     ADD: alu_out_d = rs + rt;
                     SUB: alu_out_d = rs - rt;
                     MUL: alu_out_d = rs * rt;
                     DIV: begin
                        if (rt == '0) begin
                           alu_out_d = '1;
                           dbz_d     = 1'b1;
                        end else begin
                           // alu_out keeps its old value until the quotient lands
                           state_d = DIV_RUN;
                           done_d  = 1'b0;
                        end
                     end
                     default: alu_out_d = alu_out_q;
                  endcase
               end
            end
         end
         DIV_RUN: begin
            if (div_last) begin
               alu_out_d = div_quot;
               done_d    = 1'b1;
               dbz_d     = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         alu_out_q <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_out_q <= alu_out_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy        = div_busy | div_go;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign alu_out     = alu_out_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: 8-bit unsigned, 8-bit signed-compare and 16-bit instances.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset, enable, start8, start16, cmp_mux;
   logic [1:0]  arith;
   logic [15:0] rs, rt;

   logic       busy8, done8, dbz8, busy8s, done8s, dbz8s, busy16, done16, dbz16;
   logic [7:0] alu8, alu8s;
   logic [15:0] alu16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_alu #(.DATA_WIDTH(8), .SIGNED_CMP(0)) u8 (
      .clk(clk), .reset(reset), .enable(enable), .start(start8),
      .decoded_alu_arithmetic_mux(arith), .decoded_alu_output_mux(cmp_mux),
      .rs(rs[7:0]), .rt(rt[7:0]), .busy(busy8), .done(done8),
      .div_by_zero(dbz8), .alu_out(alu8));

   seq_alu #(.DATA_WIDTH(8), .SIGNED_CMP(1)) u8s (
      .clk(clk), .reset(reset), .enable(enable), .start(start8),
      .decoded_alu_arithmetic_mux(arith), .decoded_alu_output_mux(cmp_mux),
      .rs(rs[7:0]), .rt(rt[7:0]), .busy(busy8s), .done(done8s),
      .div_by_zero(dbz8s), .alu_out(alu8s));

   seq_alu #(.DATA_WIDTH(16), .SIGNED_CMP(0)) u16 (
      .clk(clk), .reset(reset), .enable(enable), .start(start16),
      .decoded_alu_arithmetic_mux(arith), .decoded_alu_output_mux(cmp_mux),
      .rs(rs), .rt(rt), .busy(busy16), .done(done16),
      .div_by_zero(dbz16), .alu_out(alu16));

   typedef struct {
      int          sel;   // 0 = u8, 1 = u8s, 2 = u16
      bit          cmp;
      logic [1:0]  op;
      logic [15:0] a, b, exp;
      bit          dbz;
      int          lat;
      int          bsy;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: result from plain arithmetic on integers, timing from the op class.
   function automatic void model(input bit cmp, input bit sgn, input int op, input int a,
                                 input int b, input int w, output int res, output bit dbz,
                                 output int lat, output int bsy);
      int m, sa, sb;
      m = 1 << w;
      dbz = 0; lat = 1; bsy = 0; res = 0;
      if (cmp) begin
         sa = (sgn && a >= m / 2) ? a - m : a;
         sb = (sgn && b >= m / 2) ? b - m : b;
         res = (sa > sb) ? 4 : ((sa == sb) ? 2 : 1);
      end else begin
         case (op)
            0: res = (a + b) % m;
            1: res = (a - b + m) % m;
            2: res = (a * b) % m;
            default: begin
               if (b == 0) begin
                  res = m - 1;
                  dbz = 1;
               end else begin
                  res = a / b;
                  lat = w;
                  bsy = w;
               end
            end
         endcase
      end
   endfunction

   task automatic run_op(input int sel, input bit cmp, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic dbz,
                         output int lat, output int bsy);
      logic bz, dn, zz;
      logic [15:0] rr;
      tick();
      enable = 1'b1; cmp_mux = cmp; arith = op; rs = a; rt = b;
      if (sel == 2) start16 = 1'b1; else start8 = 1'b1;
      lat = -1; bsy = 0; res = 'x; dbz = 1'bx;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(negedge clk);
         case (sel)
            0: begin bz = busy8;  dn = done8;  zz = dbz8;  rr = {8'h00, alu8};  end
            1: begin bz = busy8s; dn = done8s; zz = dbz8s; rr = {8'h00, alu8s}; end
            default: begin bz = busy16; dn = done16; zz = dbz16; rr = alu16; end
         endcase
         if (bz === 1'b1) bsy++;
         if (k > 0 && dn === 1'b1) begin
            lat = k; res = rr; dbz = zz;
         end
         tick();
         start8 = 1'b0; start16 = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] res;
      logic        dbz;
      int          lat, bsy, dones, eres, elat, ebsy;
      bit          edbz;
      logic [7:0]  prev;

      reset = 1'b1; enable = 1'b0; start8 = 1'b0; start16 = 1'b0;
      cmp_mux = 1'b0; arith = 2'd0; rs = '0; rt = '0;

      tbl[0]  = '{0, 1'b0, 2'd0, 16'd7,   16'd5,  16'd12,  1'b0, 1, 0};
      tbl[1]  = '{0, 1'b0, 2'd1, 16'd3,   16'd5,  16'hFE,  1'b0, 1, 0};
      tbl[2]  = '{0, 1'b0, 2'd2, 16'd20,  16'd13, 16'h04,  1'b0, 1, 0};
      tbl[3]  = '{0, 1'b0, 2'd3, 16'd200, 16'd7,  16'd28,  1'b0, 8, 8};
      tbl[4]  = '{0, 1'b0, 2'd3, 16'd9,   16'd0,  16'hFF,  1'b1, 1, 0};
      tbl[5]  = '{0, 1'b0, 2'd0, 16'd1,   16'd1,  16'd2,   1'b0, 1, 0};
      tbl[6]  = '{0, 1'b1, 2'd0, 16'd5,   16'd9,  16'd1,   1'b0, 1, 0};
      tbl[7]  = '{0, 1'b1, 2'd0, 16'd9,   16'd9,  16'd2,   1'b0, 1, 0};
      tbl[8]  = '{0, 1'b1, 2'd0, 16'hF0,  16'h10, 16'd4,   1'b0, 1, 0};
      tbl[9]  = '{1, 1'b1, 2'd0, 16'hF0,  16'h10, 16'd1,   1'b0, 1, 0};
      tbl[10] = '{2, 1'b0, 2'd3, 16'd255, 16'd16, 16'd15,  1'b0, 16, 16};

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset alu_out", {24'h0, alu8}, 32'h0);
      chk("reset busy", {31'h0, busy8}, 32'h0);
      chk("reset done", {31'h0, done8}, 32'h0);
      chk("reset dbz", {31'h0, dbz8}, 32'h0);
      chk("reset alu16", {16'h0, alu16}, 32'h0);

      for (int i = 0; i < 11; i++) begin
         run_op(tbl[i].sel, tbl[i].cmp, tbl[i].op, tbl[i].a, tbl[i].b, res, dbz, lat, bsy);
         chk($sformatf("vec%0d result", i), {16'h0, res}, {16'h0, tbl[i].exp});
         chk($sformatf("vec%0d dbz", i), {31'h0, dbz}, {31'h0, tbl[i].dbz});
         chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
         chk($sformatf("vec%0d busy cycles", i), bsy, tbl[i].bsy);
      end

      // DIV 200/7 with a competing start in cycle 3 of the divide
      tick();
      enable = 1'b1; cmp_mux = 1'b0; arith = 2'd3; rs = 16'd200; rt = 16'd7; start8 = 1'b1;
      lat = -1; dones = 0; res = '0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 3) begin
            rs = 16'd50; rt = 16'd5; start8 = 1'b1;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
         if (done8 === 1'b1) begin
            dones++;
            if (lat < 0) begin lat = k; res = {8'h00, alu8}; end
         end
      end
      chk("busy-start latency", lat, 8);
      chk("busy-start result", {16'h0, res}, 32'd28);
      chk("busy-start done count", dones, 1);

      // reset in cycle 3 of DIV 100/3
      tick();
      arith = 2'd3; rs = 16'd100; rt = 16'd3; start8 = 1'b1;
      tick(); start8 = 1'b0;
      tick();
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      @(negedge clk);
      chk("mid-div reset busy", {31'h0, busy8}, 32'h0);
      chk("mid-div reset alu_out", {24'h0, alu8}, 32'h0);
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         @(negedge clk);
         if (done8 === 1'b1) dones++;
      end
      chk("mid-div reset no done", dones, 0);
      run_op(0, 1'b0, 2'd0, 16'd2, 16'd2, res, dbz, lat, bsy);
      chk("post-reset add result", {16'h0, res}, 32'd4);
      chk("post-reset add latency", lat, 1);

      // back-to-back: ADD issued in the done cycle of DIV 255/16
      tick();
      arith = 2'd3; rs = 16'd255; rt = 16'd16; start8 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 8) begin
            arith = 2'd0; rs = 16'd1; rt = 16'd2; start8 = 1'b1;
         end else begin
            start8 = 1'b0;
         end
      end
      @(negedge clk);
      chk("b2b div done", {31'h0, done8}, 32'h1);
      chk("b2b div result", {24'h0, alu8}, 32'd15);
      chk("b2b busy in done cycle", {31'h0, busy8}, 32'h0);
      tick(); start8 = 1'b0;
      @(negedge clk);
      chk("b2b add done", {31'h0, done8}, 32'h1);
      chk("b2b add result", {24'h0, alu8}, 32'd3);

      // start with enable low is dropped
      prev = alu8;
      tick();
      enable = 1'b0; arith = 2'd0; rs = 16'd40; rt = 16'd2; start8 = 1'b1;
      dones = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done8 === 1'b1) dones++;
         tick(); start8 = 1'b0;
      end
      chk("enable-low no done", dones, 0);
      chk("enable-low alu_out held", {24'h0, alu8}, {24'h0, prev});
      enable = 1'b1;

      for (int i = 0; i < 150; i++) begin
         int  sel, op, a, b;
         bit  cmp;
         sel = int'($urandom_range(0, 1));
         cmp = ($urandom_range(0, 3) == 0);
         op  = int'($urandom_range(0, 3));
         a   = int'($urandom_range(0, 255));
         b   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
         model(cmp, sel == 1, op, a, b, 8, eres, edbz, elat, ebsy);
         run_op(sel, cmp, 2'(op), 16'(a), 16'(b), res, dbz, lat, bsy);
         chk($sformatf("rnd%0d result", i), {16'h0, res}, eres);
         chk($sformatf("rnd%0d dbz", i), {31'h0, dbz}, {31'h0, edbz});
         chk($sformatf("rnd%0d latency", i), lat, elat);
         chk($sformatf("rnd%0d busy cycles", i), bsy, ebsy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
